// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared constants, types and helpers for the softmax result serializer
package softmax_pkg;

  localparam int ELEM_W  = 8;
  localparam int VEC_LEN = 32;
  localparam int OUT_W   = 16;
  localparam int WORDS   = VEC_LEN * ELEM_W / OUT_W;
  localparam int EPW     = OUT_W / ELEM_W;
  localparam int PTR_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(VEC_LEN);

  typedef logic [ELEM_W-1:0] sm_elem_t;
  typedef sm_elem_t sm_vec_t [VEC_LEN];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FULL  = 2'd2
  } ser_state_e;

  // Element index of lane `lane` within output word `ptr` (lane 0 is the low byte).
  function automatic logic [IDX_W-1:0] word_elem_idx(input logic [PTR_W-1:0] ptr,
                                                     input int unsigned      lane);
    return IDX_W'(ptr) * IDX_W'(EPW) + IDX_W'(lane);
  endfunction

endpackage

// File: rtl/softmax_result_serializer.sv
// rtl/softmax_result_serializer.sv - ping-pong buffered vector-to-word serializer with FWFT read port
// Optional tx_last output is enabled by defining SOFTMAX_SER_LAST_EN.
module softmax_result_serializer
  import softmax_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  sm_vec_t          data_in,
  input  logic             valid_in,
  output logic [OUT_W-1:0] tx_data,
  output logic             tx_empty,
  input  logic             tx_fifo_en,
  output logic             overflow,
  output logic             tx_last
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS - 1);

  sm_vec_t          slot_q [2];
  logic             wr_slot_q, wr_slot_d;
  logic             rd_slot_q, rd_slot_d;
  logic [PTR_W-1:0] word_ptr_q, word_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  ser_state_e       state_q, state_d;
  logic             overflow_q, overflow_d;

  logic pop, retire, accept;

  assign tx_empty = (cnt_q == 2'd0);
  assign overflow = overflow_q;

  always_comb begin
    pop    = tx_fifo_en & ~tx_empty;
    retire = pop & (word_ptr_q == LAST_PTR);
    // A retiring vector frees its slot in time for a same-cycle arrival.
    accept = valid_in & ((cnt_q != 2'd2) | retire);

    word_ptr_d = word_ptr_q;
    if (retire)   word_ptr_d = '0;
    else if (pop) word_ptr_d = word_ptr_q + PTR_W'(1);

    rd_slot_d  = rd_slot_q ^ retire;
    wr_slot_d  = wr_slot_q ^ accept;
    overflow_d = overflow_q | (valid_in & ~accept);

    cnt_d = cnt_q;
    case ({accept, retire})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRAIN;
      DRAIN: begin
        if (accept && !retire)      state_d = FULL;
        else if (retire && !accept) state_d = IDLE;
      end
      FULL:    if (retire && !accept) state_d = DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < VEC_LEN; i++) begin
          slot_q[s][i] <= '0;
        end
      end
      wr_slot_q  <= 1'b0;
      rd_slot_q  <= 1'b0;
      word_ptr_q <= '0;
      cnt_q      <= 2'd0;
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < VEC_LEN; i++) begin
          slot_q[wr_slot_q][i] <= data_in[i];
        end
      end
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      word_ptr_q <= word_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // Head word is muxed straight from slot registers (first-word-fall-through).
  always_comb begin
    tx_data = '0;
    for (int j = 0; j < EPW; j++) begin
      tx_data[j*ELEM_W +: ELEM_W] = slot_q[rd_slot_q][word_elem_idx(word_ptr_q, j)];
    end
  end

`ifdef SOFTMAX_SER_LAST_EN
  assign tx_last = ~tx_empty & (word_ptr_q == LAST_PTR);
`else
  assign tx_last = 1'b0;
`endif

endmodule
